// File: rtl/decodificador_pt2272.sv
// PT2262-style serial frame receiver: pulse-width classifier, frame FSM,
// address/data decode and valid-transmission tracking.
module decodificador_pt2272 #(
   parameter int unsigned MIN_W      = 250,
   parameter int unsigned SHORT_MAX  = 2000,
   parameter int unsigned LONG_MAX   = 4500,
   parameter int unsigned SYNC_GAP   = 10000,
   parameter int unsigned FRAMES_REQ = 2,
   parameter int unsigned TIMEOUT    = 300000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cod_i,
   input  logic [7:0] A_01,
   input  logic [7:0] A_F,
   output logic [0:3] D_o,
   output logic       vt,
   output logic       frame_ok
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned PCNT_W = 5;
   localparam int unsigned NPULSE = 24;
   localparam int unsigned MCNT_W = (FRAMES_REQ < 2) ? 1 : $clog2(FRAMES_REQ + 1);
   localparam int unsigned TO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  MIN_W_C      = CNT_W'(MIN_W);
   localparam logic [CNT_W-1:0]  SHORT_MAX_C  = CNT_W'(SHORT_MAX);
   localparam logic [CNT_W-1:0]  LONG_MAX_C   = CNT_W'(LONG_MAX);
   localparam logic [CNT_W-1:0]  SYNC_GAP_C   = CNT_W'(SYNC_GAP);
   localparam logic [MCNT_W-1:0] FREQ_C       = MCNT_W'(FRAMES_REQ);
   localparam logic [TO_W-1:0]   TIMEOUT_C    = TO_W'(TIMEOUT);
   localparam logic [PCNT_W-1:0] PULSES_DATA  = PCNT_W'(NPULSE);
   localparam logic [PCNT_W-1:0] PULSES_FRAME = PCNT_W'(NPULSE + 1);

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_RECV = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

   // Input conditioning and pulse-width counters
   logic [1:0]        sync_q;
   logic              cod_s;
   logic              cod_prev_q;
   logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0]  lo_cnt_q, lo_cnt_d;

   // Frame FSM and pulse capture
   state_e            state_q, state_d;
   logic [PCNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
   logic [NPULSE-1:0] pulse_q, pulse_d;
   logic              sync_long_q, sync_long_d;

   // Validation and outputs
   logic [0:3]        cand_q, cand_d;
   logic [MCNT_W-1:0] match_cnt_q, match_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [0:3]        d_q, d_d;
   logic              vt_q, vt_d;
   logic              frame_ok_q, frame_ok_d;

   // Combinational events
   logic              fall_c, rise_c;
   logic              hi_err_c, hi_long_c, lo_err_c, sync_ev_c;
   logic              eval_c, bad_c;
   logic              addr_ok_c, data_ok_c, good_c, bad_frame_c;
   logic [0:3]        frame_data_c;
   logic [TO_W-1:0]   to_inc_c;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign cod_s = sync_q[1];

   // Two-flop synchroniser, edge history and level-run counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q     <= '0;
         cod_prev_q <= 1'b0;
         hi_cnt_q   <= '0;
         lo_cnt_q   <= '0;
      end else begin
         sync_q     <= {sync_q[0], cod_i};
         cod_prev_q <= cod_s;
         hi_cnt_q   <= hi_cnt_d;
         lo_cnt_q   <= lo_cnt_d;
      end
   end

   // Each counter runs while its level holds and clears when the level ends
   always_comb begin
      hi_cnt_d = '0;
      lo_cnt_d = '0;
      if (cod_s) begin
         hi_cnt_d = sat_inc(hi_cnt_q);
      end else begin
         lo_cnt_d = sat_inc(lo_cnt_q);
      end
   end

   // Edge detection and width classification of the run that just ended
   always_comb begin
      fall_c    = cod_prev_q & ~cod_s;
      rise_c    = ~cod_prev_q & cod_s;
      hi_err_c  = (hi_cnt_q < MIN_W_C) || (hi_cnt_q >= LONG_MAX_C);
      hi_long_c = (hi_cnt_q >= SHORT_MAX_C);
      // A low run that ends between the longest data gap and the sync gap is malformed
      lo_err_c  = rise_c && (lo_cnt_q >= LONG_MAX_C) && (lo_cnt_q < SYNC_GAP_C);
      // lo_cnt passes SYNC_GAP once per low run, so this is a single-cycle event
      sync_ev_c = (lo_cnt_q == SYNC_GAP_C);
   end

   // Frame FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   // Pulse capture registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         pulse_cnt_q <= '0;
         pulse_q     <= '0;
         sync_long_q <= 1'b0;
      end else begin
         pulse_cnt_q <= pulse_cnt_d;
         pulse_q     <= pulse_d;
         sync_long_q <= sync_long_d;
      end
   end

   // Frame FSM next state, pulse shifting and end-of-frame events
   always_comb begin
      state_d     = state_q;
      pulse_cnt_d = pulse_cnt_q;
      pulse_d     = pulse_q;
      sync_long_d = sync_long_q;
      eval_c      = 1'b0;
      bad_c       = 1'b0;
      unique case (state_q)
         ST_HUNT: begin
            if (sync_ev_c) begin
               pulse_cnt_d = '0;
               state_d     = ST_RECV;
            end
         end
         ST_RECV: begin
            if (sync_ev_c) begin
               pulse_cnt_d = '0;
               if (pulse_cnt_q == PULSES_FRAME) begin
                  eval_c = 1'b1;
               end else begin
                  bad_c = 1'b1;
               end
            end else if (fall_c) begin
               if (hi_err_c || (pulse_cnt_q == PULSES_FRAME)) begin
                  state_d = ST_ERR;
               end else begin
                  // Pulse p lands at bit p after 24 shifts; pulse 24 is the sync pulse
                  if (pulse_cnt_q < PULSES_DATA) begin
                     pulse_d = {hi_long_c, pulse_q[NPULSE-1:1]};
                  end else begin
                     sync_long_d = hi_long_c;
                  end
                  pulse_cnt_d = pulse_cnt_q + PCNT_W'(1);
               end
            end else if (lo_err_c) begin
               state_d = ST_ERR;
            end
         end
         ST_ERR: begin
            if (sync_ev_c) begin
               bad_c       = 1'b1;
               pulse_cnt_d = '0;
               state_d     = ST_RECV;
            end
         end
         default: begin
            state_d = ST_HUNT;
         end
      endcase
   end

   // Symbol decode: address compare against local setting and data extraction
   always_comb begin
      addr_ok_c    = 1'b1;
      data_ok_c    = 1'b1;
      frame_data_c = '0;
      for (int k = 0; k < 8; k++) begin
         if (A_F[3'(k)]) begin
            if (pulse_q[5'(2 * k)] || !pulse_q[5'(2 * k + 1)]) begin
               addr_ok_c = 1'b0;
            end
         end else if ((pulse_q[5'(2 * k)] != A_01[3'(k)]) ||
                      (pulse_q[5'(2 * k + 1)] != A_01[3'(k)])) begin
            addr_ok_c = 1'b0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         frame_data_c[2'(i)] = pulse_q[5'(16 + 2 * i)];
         if (pulse_q[5'(16 + 2 * i)] != pulse_q[5'(17 + 2 * i)]) begin
            data_ok_c = 1'b0;
         end
      end
      good_c      = eval_c && addr_ok_c && data_ok_c && !sync_long_q;
      bad_frame_c = bad_c || (eval_c && !good_c);
   end

   // Candidate tracking, acceptance and valid-transmission timeout
   always_comb begin
      frame_ok_d  = 1'b0;
      cand_d      = cand_q;
      match_cnt_d = match_cnt_q;
      d_d         = d_q;
      vt_d        = vt_q;
      to_cnt_d    = to_cnt_q;
      to_inc_c    = to_cnt_q + TO_W'(1);
      if (vt_q) begin
         if (to_inc_c == TIMEOUT_C) begin
            vt_d     = 1'b0;
            to_cnt_d = '0;
         end else begin
            to_cnt_d = to_inc_c;
         end
      end
      if (good_c) begin
         frame_ok_d = 1'b1;
         if (frame_data_c == cand_q) begin
            match_cnt_d = (match_cnt_q == FREQ_C) ? match_cnt_q : match_cnt_q + MCNT_W'(1);
         end else begin
            cand_d      = frame_data_c;
            match_cnt_d = MCNT_W'(1);
         end
         // Acceptance overrides an expiring timeout on the same edge
         if (match_cnt_d == FREQ_C) begin
            d_d      = cand_d;
            vt_d     = 1'b1;
            to_cnt_d = '0;
         end
      end else if (bad_frame_c) begin
         match_cnt_d = '0;
      end
   end

   // Output and validation registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         cand_q      <= '0;
         match_cnt_q <= '0;
         to_cnt_q    <= '0;
         d_q         <= '0;
         vt_q        <= 1'b0;
         frame_ok_q  <= 1'b0;
      end else begin
         cand_q      <= cand_d;
         match_cnt_q <= match_cnt_d;
         to_cnt_q    <= to_cnt_d;
         d_q         <= d_d;
         vt_q        <= vt_d;
         frame_ok_q  <= frame_ok_d;
      end
   end

   assign D_o      = d_q;
   assign vt       = vt_q;
   assign frame_ok = frame_ok_q;

endmodule
